// File: rtl/gate_response_checker.sv
// Checks a combinational DUT output against a golden truth table after each vector settles.
// Latency: check lands SETTLE_CYCLES edges after vec_in changes (+2 with GATE_CHECKER_SYNC_EN).
// Backpressure: none; observes passively and never stalls the stimulus.
module gate_response_checker #(
    parameter int                   N_IN          = 4,
    parameter logic [(2**N_IN)-1:0] TRUTH         = 16'h8000,
    parameter int                   SETTLE_CYCLES = 8,
    parameter int                   CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [N_IN-1:0]        vec_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       check_cnt,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic                   first_fail_valid,
    output logic [N_IN-1:0]        first_fail_vec,
    output logic [(2**N_IN)-1:0]   covered
);

    localparam int SC_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CHK_AT = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;

    localparam logic [SC_W-1:0]  CHK_AT_V = SC_W'(CHK_AT);
    localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CHECKED = 2'd2,
        DONE    = 2'd3
    } state_t;

    logic [N_IN-1:0] vs;
    logic            ds;
    logic [N_IN-1:0] vs_prev;
    logic            stable;

    state_t          state_q, state_d;
    logic [SC_W-1:0] cnt_q, cnt_d;
    logic            clear;
    logic            do_check;

`ifdef GATE_CHECKER_SYNC_EN
    logic [N_IN-1:0] vec_s1, vec_s2;
    logic            out_s1, out_s2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vec_s1 <= '0;
            vec_s2 <= '0;
            out_s1 <= 1'b0;
            out_s2 <= 1'b0;
        end else begin
            vec_s1 <= vec_in;
            vec_s2 <= vec_s1;
            out_s1 <= dut_out;
            out_s2 <= out_s1;
        end
    end

    assign vs = vec_s2;
    assign ds = out_s2;
`else
    assign vs = vec_in;
    assign ds = dut_out;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_prev <= '0;
        end else begin
            vs_prev <= vs;
        end
    end

    assign stable = (vs == vs_prev);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The check fires on the edge where the settle count would reach SETTLE_CYCLES-1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear    = 1'b0;
        do_check = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!stable) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + SC_ONE;
                    if (cnt_q == CHK_AT_V) begin
                        do_check = 1'b1;
                        state_d  = CHECKED;
                    end
                end
                if (stop) begin
                    state_d = DONE;
                end
            end
            CHECKED: begin
                if (!stable) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
                if (stop) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            check_cnt        <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            covered          <= '0;
        end else if (clear) begin
            check_cnt        <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            covered          <= '0;
        end else if (do_check) begin
            if (check_cnt != CNT_MAX) begin
                check_cnt <= check_cnt + CNT_ONE;
            end
            covered[vs] <= 1'b1;
            if (ds != TRUTH[vs]) begin
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + CNT_ONE;
                end
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= vs;
                end
            end
        end
    end

    assign busy = (state_q == SETTLE) || (state_q == CHECKED);
    assign done = (state_q == DONE);
    assign pass = done && (mismatch_cnt == '0) && (check_cnt != '0);

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: expected checks queued at stimulus, popped as check_cnt steps.
module tb_gate_response_checker;

`ifdef GATE_CHECKER_SYNC_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 8;
`endif

    logic        clk;
    logic        rstn;
    logic        start;
    logic        stop;
    logic [3:0]  vec_in;
    logic        dut_out;

    logic        busy, done, pass, first_fail_valid;
    logic [15:0] check_cnt, mismatch_cnt, covered;
    logic [3:0]  first_fail_vec;

    logic        s_busy, s_done, s_pass, s_ffv;
    logic [1:0]  s_check_cnt, s_mismatch_cnt;
    logic [15:0] s_covered;
    logic [3:0]  s_ffvec;

    typedef struct packed {
        logic [3:0] vec;
        logic       mis;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] truth_tb = 16'h8000;
    logic [15:0] last_chk, last_mis;
    int          tests = 0;
    int          fails = 0;

    gate_response_checker #(.N_IN(4), .TRUTH(16'h8000), .SETTLE_CYCLES(8), .CNT_W(16)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .vec_in(vec_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .check_cnt(check_cnt), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec), .covered(covered)
    );

    gate_response_checker #(.N_IN(4), .TRUTH(16'h8000), .SETTLE_CYCLES(8), .CNT_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .vec_in(vec_in), .dut_out(dut_out),
        .busy(s_busy), .done(s_done), .pass(s_pass), .check_cnt(s_check_cnt),
        .mismatch_cnt(s_mismatch_cnt), .first_fail_valid(s_ffv), .first_fail_vec(s_ffvec),
        .covered(s_covered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic d, input bit expect_check);
        exp_t e;
        vec_in  = v;
        dut_out = d;
        if (expect_check) begin
            e.vec = v;
            e.mis = (d != truth_tb[v]);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    // Each step of check_cnt consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rstn) begin
            last_chk = '0;
            last_mis = '0;
        end else begin
            if (check_cnt == last_chk + 16'd1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_check", {16'd0, check_cnt}, {16'd0, last_chk});
                end else begin
                    mon_e = sb.pop_front();
                    chk("mis_delta", {16'd0, mismatch_cnt - last_mis}, {31'd0, mon_e.mis});
                    chk("covered_bit", {31'd0, covered[mon_e.vec]}, 32'd1);
                end
            end else if (check_cnt > last_chk) begin
                chk("check_jump", {16'd0, check_cnt}, {16'd0, last_chk + 16'd1});
            end
            last_chk = check_cnt;
            last_mis = mismatch_cnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; vec_in = '0; dut_out = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            vec_in  = 4'($urandom);
            dut_out = 1'($urandom);
            start   = 1'($urandom);
            stop    = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_check_cnt", {16'd0, check_cnt}, 32'd0);
        chk("rst_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd0);
        chk("rst_ffv", {31'd0, first_fail_valid}, 32'd0);
        chk("rst_ffvec", {28'd0, first_fail_vec}, 32'd0);
        chk("rst_covered", {16'd0, covered}, 32'd0);
        start = 1'b0; stop = 1'b0; vec_in = '0; dut_out = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        tick(2);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        tick(1);

        // Pass run: one settled matching vector.
        apply(4'hF, 1'b1, 1'b1);
        pulse_start();
        tick(11);
        pulse_stop();
        @(negedge clk);
        chk("pass_check_cnt", {16'd0, check_cnt}, 32'd1);
        chk("pass_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd0);
        chk("pass_covered", {16'd0, covered}, 32'h8000);
        chk("pass_done", {31'd0, done}, 32'd1);
        chk("pass_busy", {31'd0, busy}, 32'd0);
        chk("pass_pass", {31'd0, pass}, 32'd1);
        tick(1);

        // Fail capture: two mismatching vectors, the first is latched.
        apply(4'h3, 1'b1, 1'b1);
        pulse_start();
        tick(11);
        apply(4'h5, 1'b1, 1'b1);
        tick(12);
        pulse_stop();
        @(negedge clk);
        chk("fail_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd2);
        chk("fail_check_cnt", {16'd0, check_cnt}, 32'd2);
        chk("fail_ffvec", {28'd0, first_fail_vec}, 32'h3);
        chk("fail_ffv", {31'd0, first_fail_valid}, 32'd1);
        chk("fail_pass", {31'd0, pass}, 32'd0);
        chk("fail_covered", {16'd0, covered}, 32'h0028);
        tick(1);

        // Glitch rejection, then latency of a held vector.
        apply(4'h1, 1'b0, 1'b0);
        pulse_start();
        tick(4);
        for (int i = 1; i < 10; i++) begin
            apply((i % 2 == 1) ? 4'h2 : 4'h1, 1'b0, 1'b0);
            tick(5);
        end
        @(negedge clk);
        chk("glitch_check_cnt", {16'd0, check_cnt}, 32'd0);
        tick(1);
        apply(4'h6, 1'b0, 1'b1);
        tick(LAT - 1);
        @(negedge clk);
        chk("lat_before_check", {16'd0, check_cnt}, 32'd0);
        tick(1);
        @(negedge clk);
        chk("lat_at_check", {16'd0, check_cnt}, 32'd1);
        tick(1);
        pulse_stop();

        // Stop sampled on the exact check edge.
        apply(4'h9, 1'b0, 1'b1);
        pulse_start();
        tick(LAT - 2);
        pulse_stop();
        @(negedge clk);
        chk("stopedge_check_cnt", {16'd0, check_cnt}, 32'd1);
        chk("stopedge_done", {31'd0, done}, 32'd1);
        chk("stopedge_pass", {31'd0, pass}, 32'd1);
        tick(1);

        // Start while busy is ignored, in CHECKED and in SETTLE.
        apply(4'hA, 1'b0, 1'b1);
        pulse_start();
        tick(11);
        pulse_start();
        @(negedge clk);
        chk("busy_start_busy", {31'd0, busy}, 32'd1);
        chk("busy_start_check_cnt", {16'd0, check_cnt}, 32'd1);
        chk("busy_start_covered", {16'd0, covered}, 32'h0400);
        tick(1);
        apply(4'hC, 1'b1, 1'b1);
        tick(2);
        pulse_start();
        tick(10);
        @(negedge clk);
        chk("settle_start_check_cnt", {16'd0, check_cnt}, 32'd2);
        chk("settle_start_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd1);
        chk("settle_start_ffvec", {28'd0, first_fail_vec}, 32'hC);
        tick(1);
        pulse_stop();

        // Asynchronous reset mid-run.
        apply(4'hF, 1'b0, 1'b1);
        pulse_start();
        tick(LAT + 2);
        rstn = 1'b0;
        #2;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_pass", {31'd0, pass}, 32'd0);
        chk("midrst_check_cnt", {16'd0, check_cnt}, 32'd0);
        chk("midrst_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd0);
        chk("midrst_ffv", {31'd0, first_fail_valid}, 32'd0);
        chk("midrst_covered", {16'd0, covered}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick(1);
        @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        tick(1);

        // Saturation on the narrow-counter instance.
        apply(4'h0, 1'b1, 1'b1);
        pulse_start();
        tick(11);
        for (int v = 1; v < 5; v++) begin
            apply(4'(v), 1'b1, 1'b1);
            tick(12);
        end
        pulse_stop();
        @(negedge clk);
        chk("sat_mismatch_cnt", {30'd0, s_mismatch_cnt}, 32'd3);
        chk("sat_check_cnt", {30'd0, s_check_cnt}, 32'd3);
        chk("sat_covered", {16'd0, s_covered}, 32'h001F);
        chk("sat_done", {31'd0, s_done}, 32'd1);
        chk("sat_pass", {31'd0, s_pass}, 32'd0);
        chk("sat_ffvec", {28'd0, s_ffvec}, 32'h0);
        chk("wide_check_cnt", {16'd0, check_cnt}, 32'd5);
        chk("wide_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd5);

        tick(2);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
